// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: aligns core accesses onto a word-wide req/ack data bus,
// stalls the core while the bus transaction runs and aborts on bus timeout.
module lsu_bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              misaligned,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t          state_reg, state_next;
   logic [TO_W-1:0] count_reg;

   logic        req_any, access, timeout_hit;
   logic        is_byte, is_half, is_word;
   logic [3:0]  be_lane;
   logic [31:0] wdata_lane, rdata_lane;

   assign req_any     = mem_read | mem_write;
   assign is_byte     = (size == 2'b10);
   assign is_half     = (size == 2'b01);
   assign is_word     = ~is_byte & ~is_half;   // 00 and 11 both mean word
   assign misaligned  = req_any & ((is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]));
   assign access      = req_any & ~misaligned;
   // The core is released only in DONE; misaligned accesses never stall.
   assign stall       = access & (state_reg != DONE);
   assign timeout_hit = (count_reg == TO_W'(TIMEOUT - 1));

   // Lane steering: replicate store data across lanes, pick the addressed lane on loads.
   always_comb begin
      be_lane    = 4'b1111;
      wdata_lane = wdata;
      rdata_lane = bus_rdata;
      if (is_byte) begin
         be_lane    = 4'b0001 << addr[1:0];
         wdata_lane = {4{wdata[7:0]}};
         rdata_lane = {24'd0, bus_rdata[{addr[1:0], 3'b000} +: 8]};
      end else if (is_half) begin
         be_lane    = addr[1] ? 4'b1100 : 4'b0011;
         wdata_lane = {2{wdata[15:0]}};
         rdata_lane = {16'd0, (addr[1] ? bus_rdata[31:16] : bus_rdata[15:0])};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic: one REQ phase per access, DONE lasts exactly one cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (access) state_next = REQ;
         REQ:     if (bus_ack || timeout_hit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus request, timeout counter and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'd0;
         bus_err   <= 1'b0;
         rdata     <= 32'd0;
         count_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (access) begin
                  bus_req   <= 1'b1;
                  bus_we    <= mem_write;   // read+write together is a write
                  bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus_be    <= be_lane;
                  bus_wdata <= wdata_lane;
                  count_reg <= '0;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  bus_req   <= 1'b0;
                  count_reg <= '0;
                  rdata     <= bus_we ? 32'd0 : rdata_lane;
               end else if (timeout_hit) begin
                  bus_req   <= 1'b0;
                  bus_err   <= 1'b1;
                  count_reg <= '0;
                  rdata     <= 32'd0;
               end else begin
                  count_reg <= count_reg + 1'b1;
               end
            end
            DONE:    bus_err <= 1'b0;
            default: bus_err <= 1'b0;
         endcase
      end
   end

endmodule
